// File: rtl/vsfx_pkg.sv
// Shared definitions for the VSFX issue controller: opcodes, FSM encoding,
// CR6 encodings, the FIFO entry layout and small decode helpers.
package vsfx_pkg;

    localparam logic [7:0] OP_VADDSWS  = 8'h70;
    localparam logic [7:0] OP_VSUBUBM  = 8'h80;
    localparam logic [7:0] OP_VAVGSH   = 8'hA9;
    localparam logic [7:0] OP_VCMPEQUH = 8'h0B;
    localparam logic [7:0] OP_VSLB     = 8'h22;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [3:0] CR6_ALL  = 4'b1000;
    localparam logic [3:0] CR6_NONE = 4'b0010;

    typedef struct packed {
        logic [7:0]   ins;
        logic [127:0] vra;
        logic [127:0] vrb;
        logic [4:0]   tag;
    } vsfx_entry_t;

    function automatic logic is_legal(input logic [7:0] op);
        logic ok;
        case (op)
            OP_VADDSWS, OP_VSUBUBM, OP_VAVGSH, OP_VCMPEQUH, OP_VSLB: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] cr6_of(input logic [127:0] v);
        logic [3:0] c;
        if (&v) begin
            c = CR6_ALL;
        end else if (~|v) begin
            c = CR6_NONE;
        end else begin
            c = 4'b0000;
        end
        return c;
    endfunction

endpackage

// File: rtl/vsfx_issue_fifo.sv
// Instruction buffer for the VSFX issue controller: DEPTH entries with
// wrapping pointers (extra MSB distinguishes full from empty).
module vsfx_issue_fifo
    import vsfx_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  vsfx_entry_t wr_data,
    output vsfx_entry_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    vsfx_entry_t    mem_r [DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full && !clr;
    assign do_pop_s  = pop && !empty && !clr;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; clear discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/vsfx_issue_ctrl.sv
// VSFX issue controller: queues vector instructions, rejects illegal opcodes,
// issues one op at a time to the datapath and returns results on a
// backpressured writeback port with sticky SAT and CR6 generation.
module vsfx_issue_ctrl
    import vsfx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DP_LAT = 1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_ins,
    input  logic [127:0] in_vra,
    input  logic [127:0] in_vrb,
    input  logic [4:0]   in_tag,
    output logic         dp_en,
    output logic [7:0]   dp_ins,
    output logic [127:0] dp_vra,
    output logic [127:0] dp_vrb,
    input  logic [127:0] dp_vrt,
    input  logic         dp_sat,
    input  logic         dp_vrt_en,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [4:0]   wb_tag,
    output logic [127:0] wb_data,
    output logic [3:0]   wb_cr6,
    output logic         wb_cr6_we,
    output logic         sat_sticky,
    input  logic         sat_clr,
    output logic         illegal,
    output logic         proto_err,
    output logic         busy
);

    localparam int CNT_W = $clog2(DP_LAT + 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    vsfx_entry_t      in_entry_s;
    vsfx_entry_t      head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_push_s;
    logic             in_ready_s;

    logic             take_s;
    logic             issue_s;
    logic             reject_s;
    logic             capture_s;
    logic             hs_s;
    logic             sat_set_s;

    logic             dp_en_r;
    logic [7:0]       dp_ins_r;
    logic [127:0]     dp_vra_r;
    logic [127:0]     dp_vrb_r;
    logic [4:0]       tag_r;

    logic             wb_valid_r;
    logic [4:0]       wb_tag_r;
    logic [127:0]     wb_data_r;
    logic [3:0]       wb_cr6_r;
    logic             wb_cr6_we_r;
    logic             sat_sticky_r;
    logic             illegal_r;
    logic             proto_err_r;

    assign in_entry_s  = '{ins: in_ins, vra: in_vra, vrb: in_vrb, tag: in_tag};
    assign in_ready_s  = rst_n && !fifo_full_s && !flush;
    assign fifo_push_s = in_valid && in_ready_s;

    vsfx_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .push    (fifo_push_s),
        .pop     (take_s),
        .wr_data (in_entry_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // The head may leave the FIFO from IDLE or straight out of a WB handshake.
    assign take_s    = !flush && !fifo_empty_s &&
                       ((state_r == ST_IDLE) || ((state_r == ST_WB) && wb_ready));
    assign issue_s   = take_s && is_legal(head_s.ins);
    assign reject_s  = take_s && !is_legal(head_s.ins);
    assign capture_s = !flush && (state_r == ST_EXEC) && (cnt_r == '0);
    assign hs_s      = !flush && (state_r == ST_WB) && wb_ready;
    assign sat_set_s = capture_s && (dp_ins_r == OP_VADDSWS) && dp_sat;

    // Next-state selection; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_nxt_s = issue_s ? ST_EXEC : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM state and datapath latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                cnt_r <= CNT_W'(DP_LAT);
            end else if ((state_r == ST_EXEC) && (cnt_r != '0)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    // Datapath operand registers; held from one issue to the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_en_r  <= 1'b0;
            dp_ins_r <= 8'h00;
            dp_vra_r <= '0;
            dp_vrb_r <= '0;
            tag_r    <= 5'd0;
        end else if (flush) begin
            dp_en_r  <= 1'b0;
        end else begin
            dp_en_r <= issue_s;
            if (issue_s) begin
                dp_ins_r <= head_s.ins;
                dp_vra_r <= head_s.vra;
                dp_vrb_r <= head_s.vrb;
                tag_r    <= head_s.tag;
            end
        end
    end

    // Writeback register set; stays frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_r  <= 1'b0;
            wb_tag_r    <= 5'd0;
            wb_data_r   <= '0;
            wb_cr6_r    <= 4'b0000;
            wb_cr6_we_r <= 1'b0;
        end else if (flush) begin
            wb_valid_r  <= 1'b0;
        end else if (capture_s) begin
            wb_valid_r  <= 1'b1;
            wb_tag_r    <= tag_r;
            wb_data_r   <= dp_vrt;
            wb_cr6_we_r <= (dp_ins_r == OP_VCMPEQUH);
            wb_cr6_r    <= (dp_ins_r == OP_VCMPEQUH) ? cr6_of(dp_vrt) : 4'b0000;
        end else if (hs_s) begin
            wb_valid_r  <= 1'b0;
        end
    end

    // Status flags: illegal pulse, sticky protocol error, sticky SAT (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r    <= 1'b0;
            proto_err_r  <= 1'b0;
            sat_sticky_r <= 1'b0;
        end else begin
            illegal_r <= reject_s;
            if (capture_s && !dp_vrt_en) begin
                proto_err_r <= 1'b1;
            end
            if (sat_set_s) begin
                sat_sticky_r <= 1'b1;
            end else if (sat_clr) begin
                sat_sticky_r <= 1'b0;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign dp_en      = dp_en_r;
    assign dp_ins     = dp_ins_r;
    assign dp_vra     = dp_vra_r;
    assign dp_vrb     = dp_vrb_r;
    assign wb_valid   = wb_valid_r;
    assign wb_tag     = wb_tag_r;
    assign wb_data    = wb_data_r;
    assign wb_cr6     = wb_cr6_r;
    assign wb_cr6_we  = wb_cr6_we_r;
    assign sat_sticky = sat_sticky_r;
    assign illegal    = illegal_r;
    assign proto_err  = proto_err_r;
    assign busy       = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_vsfx_issue_ctrl.sv
// Scoreboard bench for vsfx_issue_ctrl with a behavioural VSFX datapath model.
module tb_vsfx_issue_ctrl;

    localparam int DEPTH  = 4;
    localparam int DP_LAT = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_ins = 8'h00;
    logic [127:0] in_vra = '0;
    logic [127:0] in_vrb = '0;
    logic [4:0]   in_tag = 5'd0;
    logic         dp_en;
    logic [7:0]   dp_ins;
    logic [127:0] dp_vra, dp_vrb, dp_vrt;
    logic         dp_sat, dp_vrt_en;
    logic         wb_valid;
    logic         wb_ready = 1'b1;
    logic [4:0]   wb_tag;
    logic [127:0] wb_data;
    logic [3:0]   wb_cr6;
    logic         wb_cr6_we;
    logic         sat_sticky;
    logic         sat_clr = 1'b0;
    logic         illegal, proto_err, busy;

    typedef struct {
        logic [4:0]   tag;
        logic [127:0] data;
        logic [3:0]   cr6;
        logic         we;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   wb_cnt = 0;
    int   ill_cnt = 0;
    int   den_cnt = 0;
    logic [DP_LAT-1:0] dp_pipe;

    vsfx_issue_ctrl #(.DEPTH(DEPTH), .DP_LAT(DP_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
        .in_vra(in_vra), .in_vrb(in_vrb), .in_tag(in_tag),
        .dp_en(dp_en), .dp_ins(dp_ins), .dp_vra(dp_vra), .dp_vrb(dp_vrb),
        .dp_vrt(dp_vrt), .dp_sat(dp_sat), .dp_vrt_en(dp_vrt_en),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_cr6(wb_cr6), .wb_cr6_we(wb_cr6_we),
        .sat_sticky(sat_sticky), .sat_clr(sat_clr),
        .illegal(illegal), .proto_err(proto_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath model: result is a function of the held operands; valid DP_LAT cycles after dp_en.
    function automatic logic [128:0] dp_fn(input logic [7:0] op, input logic [127:0] a, input logic [127:0] b);
        logic [127:0]       r;
        logic               s;
        logic signed [32:0] sw;
        logic signed [16:0] sh;
        r = '0;
        s = 1'b0;
        case (op)
            8'h70: for (int i = 0; i < 4; i++) begin
                sw = $signed({a[32*i+31], a[32*i +: 32]}) + $signed({b[32*i+31], b[32*i +: 32]});
                if (sw[32] != sw[31]) begin
                    r[32*i +: 32] = sw[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    s = 1'b1;
                end else begin
                    r[32*i +: 32] = sw[31:0];
                end
            end
            8'h80: for (int i = 0; i < 16; i++) r[8*i +: 8] = a[8*i +: 8] - b[8*i +: 8];
            8'hA9: for (int i = 0; i < 8; i++) begin
                sh = $signed({a[16*i+15], a[16*i +: 16]}) + $signed({b[16*i+15], b[16*i +: 16]}) + 17'sd1;
                r[16*i +: 16] = sh[16:1];
            end
            8'h0B: for (int i = 0; i < 8; i++) r[16*i +: 16] = (a[16*i +: 16] == b[16*i +: 16]) ? 16'hFFFF : 16'h0000;
            8'h22: for (int i = 0; i < 16; i++) r[8*i +: 8] = a[8*i +: 8] << b[8*i +: 3];
            default: r = '0;
        endcase
        return {s, r};
    endfunction

    assign {dp_sat, dp_vrt} = dp_fn(dp_ins, dp_vra, dp_vrb);
    assign dp_vrt_en = dp_pipe[DP_LAT-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_pipe <= '0;
        else        dp_pipe <= {dp_pipe, dp_en};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per writeback handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wb_valid && wb_ready) begin
            check("wb_expected_pending", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_tag", 128'(wb_tag), 128'(e.tag));
                check("wb_data", wb_data, e.data);
                check("wb_cr6", 128'(wb_cr6), 128'(e.cr6));
                check("wb_cr6_we", 128'(wb_cr6_we), 128'(e.we));
            end
            wb_cnt++;
        end
        if (illegal) ill_cnt++;
        if (dp_en) den_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] tag, input logic [127:0] data, input logic [3:0] cr6, input logic we);
        exp_t e;
        e.tag = tag; e.data = data; e.cr6 = cr6; e.we = we;
        exp_q.push_back(e);
    endtask

    // Offers one instruction; returns just after the accepting edge.
    task automatic send(input logic [7:0] ins, input logic [127:0] a, input logic [127:0] b, input logic [4:0] tag);
        int n;
        in_valid = 1'b1; in_ins = ins; in_vra = a; in_vrb = b; in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept_timeout", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !wb_valid && exp_q.size() == 0) break;
        end
        check(name, 128'(busy), 128'd0);
        check({name, "_queue"}, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int lat, ill0, den0, wb0;
        logic [7:0] k8;

        // Reset values.
        #3;
        check("in_ready_in_reset", 128'(in_ready), 128'd0);
        repeat (3) @(negedge clk);
        check("rst_wb_valid", 128'(wb_valid), 128'd0);
        check("rst_dp_en", 128'(dp_en), 128'd0);
        check("rst_sat", 128'(sat_sticky), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_illegal", 128'(illegal), 128'd0);
        step();

        // Saturating vaddsws: latency, tag echo, sticky SAT.
        expect_wb(5'd7, 128'h7FFF_FFFF, 4'b0000, 1'b0);
        den0 = den_cnt;
        send(8'h70, 128'h7FFF_FFFF, 128'h1, 5'd7);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (wb_valid) break;
        end
        check("latency", 128'(lat), 128'd3);
        check("dp_en_one_cycle", 128'(den_cnt - den0), 128'd1);
        step();
        @(negedge clk);
        check("sat_set", 128'(sat_sticky), 128'd1);
        step();
        expect_wb(5'd8, 128'h3, 4'b0000, 1'b0);
        send(8'h70, 128'h1, 128'h2, 5'd8);
        wait_idle("idle_after_add");
        check("sat_stays", 128'(sat_sticky), 128'd1);

        // CR6 generation and a non-compare op.
        step();
        expect_wb(5'd1, {128{1'b1}}, 4'b1000, 1'b1);
        send(8'h0B, {8{16'h1234}}, {8{16'h1234}}, 5'd1);
        expect_wb(5'd2, 128'h0, 4'b0010, 1'b1);
        send(8'h0B, 128'h0, {128{1'b1}}, 5'd2);
        expect_wb(5'd3, {{112{1'b1}}, 16'h0000}, 4'b0000, 1'b1);
        send(8'h0B, 128'h0, 128'h1, 5'd3);
        expect_wb(5'd4, {16{8'hFE}}, 4'b0000, 1'b0);
        send(8'h80, {16{8'h05}}, {16{8'h07}}, 5'd4);
        wait_idle("idle_after_cmp");

        // Fill under backpressure: one op in WB plus DEPTH queued.
        step();
        wb_ready = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            k8 = 8'(k);
            expect_wb(5'(k), {16{k8}} << 1, 4'b0000, 1'b0);
            send(8'h22, {16{k8}}, {16{8'h01}}, 5'(k));
        end
        repeat (2) @(negedge clk);
        check("full_in_ready", 128'(in_ready), 128'd0);
        check("full_wb_valid", 128'(wb_valid), 128'd1);
        check("full_busy", 128'(busy), 128'd1);
        step();
        wb_ready = 1'b1;
        wait_idle("idle_after_fill");

        // Illegal opcode between two vslb.
        step();
        ill0 = ill_cnt; den0 = den_cnt; wb0 = wb_cnt;
        expect_wb(5'd10, {16{8'h02}}, 4'b0000, 1'b0);
        send(8'h22, {16{8'h81}}, {16{8'h01}}, 5'd10);
        send(8'hFF, {16{8'h11}}, {16{8'h22}}, 5'd11);
        expect_wb(5'd12, {16{8'hF0}}, 4'b0000, 1'b0);
        send(8'h22, {16{8'h0F}}, {16{8'h04}}, 5'd12);
        wait_idle("idle_after_illegal");
        check("illegal_pulses", 128'(ill_cnt - ill0), 128'd1);
        check("illegal_dp_en", 128'(den_cnt - den0), 128'd2);
        check("illegal_wb_count", 128'(wb_cnt - wb0), 128'd2);

        // Clear SAT, then flush a saturating op in EXEC with two queued.
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        @(negedge clk);
        check("sat_clr", 128'(sat_sticky), 128'd0);
        step();
        wb0 = wb_cnt;
        send(8'h70, 128'h7FFF_FFFF, 128'h7FFF_FFFF, 5'd20);
        send(8'h22, 128'h1, 128'h1, 5'd21);
        send(8'h22, 128'h2, 128'h1, 5'd22);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 128'(in_ready), 128'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 128'(busy), 128'd0);
        check("flush_wb_valid", 128'(wb_valid), 128'd0);
        repeat (4) @(negedge clk);
        check("flush_no_wb", 128'(wb_cnt - wb0), 128'd0);
        check("flush_sat", 128'(sat_sticky), 128'd0);
        step();
        expect_wb(5'd23, {8{16'h0004}}, 4'b0000, 1'b0);
        send(8'hA9, {8{16'h0003}}, {8{16'h0004}}, 5'd23);
        wait_idle("idle_after_flush");

        // sat_clr coincident with a saturating capture: set wins.
        step();
        expect_wb(5'd24, {32'h8000_0000, 96'h0}, 4'b0000, 1'b0);
        send(8'h70, {32'h8000_0000, 96'h0}, {32'hFFFF_FFFF, 96'h0}, 5'd24);
        step();
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        @(negedge clk);
        check("setclr_wb_valid", 128'(wb_valid), 128'd1);
        check("setclr_sat", 128'(sat_sticky), 128'd1);
        wait_idle("idle_after_setclr");
        check("proto_err", 128'(proto_err), 128'd0);

        // Asynchronous reset while a result waits in WB.
        step();
        wb_ready = 1'b0;
        send(8'h22, 128'h5, 128'h1, 5'd25);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_valid) break;
        end
        check("pre_reset_wb_valid", 128'(wb_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wb_valid", 128'(wb_valid), 128'd0);
        check("async_rst_busy", 128'(busy), 128'd0);
        check("async_rst_sat", 128'(sat_sticky), 128'd0);
        check("async_rst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_wb_valid", 128'(wb_valid), 128'd0);
        check("post_rst_in_ready", 128'(in_ready), 128'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vsfx_issue_ctrl.md
# vsfx_issue_ctrl

Issue controller for the vector simple fixed-point (VSFX) unit. Buffers incoming vector instructions in a small FIFO, decodes and rejects unsupported opcodes, and drives the VSFX datapath one operation at a time. It waits out the datapath's fixed latency, then presents the result on a backpressured writeback port. It also maintains the sticky VSCR[SAT] bit and generates CR6 for compares.

## Interface
- DEPTH, 4, instruction FIFO entries (power of 2, ≥2)
- DP_LAT, 1, datapath latency in cycles from dp_en to valid dp_vrt (≥1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops queued and in-flight work
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept (= !full && !flush; 0 while rst_n low)
- in_ins  in  8  opcode (ins[21:25],ins[28:30])
- in_vra, in_vrb  in  128  source operands
- in_tag  in  5  destination VR index
- dp_en, dp_ins[8], dp_vra[128], dp_vrb[128]  out  to datapath
- dp_vrt  in  128, dp_sat  in  1, dp_vrt_en  in  1  from datapath
- wb_valid  out  1; wb_ready  in  1; wb_tag  out  5; wb_data  out  128
- wb_cr6  out  4; wb_cr6_we  out  1  (qualified by wb_valid)
- sat_sticky  out  1; sat_clr  in  1  (mtvscr clear)
- illegal  out  1  one-cycle pulse per rejected opcode
- proto_err  out  1  sticky; dp_vrt_en low at capture
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- Legal opcodes: 0x70 vaddsws, 0x80 vsububm, 0xA9 vavgsh, 0x0B vcmpequh, 0x22 vslb. All other opcodes are illegal.
- FIFO push on in_valid && in_ready. Full FIFO: in_ready=0, no bypass.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head.
    - Illegal head: pulse illegal, stay IDLE.
    - Legal head: load dp_* registers, dp_en=1 for exactly one cycle, cnt←DP_LAT, go to EXEC.
  - EXEC: decrement cnt each cycle. When cnt==0, capture dp_vrt/dp_sat, set proto_err if !dp_vrt_en, go to WB.
  - WB: hold wb_valid and all wb_* stable until wb_ready. On handshake, if FIFO non-empty, issue the next head directly (WB→EXEC or illegal pulse); else go to IDLE.
- dp_ins/dp_vra/dp_vrb stay stable from issue until the next issue.
- Sticky SAT:
  - Set when the captured op is vaddsws and dp_sat=1.
  - sat_clr clears it.
  - If set and clear occur in the same cycle, set wins.
  - Flush does not clear it.
- CR6 (vcmpequh only, wb_cr6_we=1):
  - 4'b1000 if dp_vrt is all ones.
  - 4'b0010 if dp_vrt is all zeros.
  - Otherwise 4'b0000.
  - For other ops, wb_cr6=0 and wb_cr6_we=0.
- Flush:
  - Empties the FIFO, forces IDLE, drops wb_valid and dp_en the next cycle.
  - Results of the flushed op are discarded.
  - in_ready=0 during the flush cycle.
  - Flush has priority over every other event.

## Timing
- Reset: all registered outputs 0 (wb_*, dp_*, illegal, proto_err, sat_sticky); FSM=IDLE; FIFO empty.
- Accept at edge E0 → issue at E1 (dp_en high E1–E2) → capture at E1+DP_LAT+1 → wb_valid high from that edge.
- Minimum accept→wb_valid latency = DP_LAT+2 cycles.
- Back-to-back throughput: one op per DP_LAT+2 cycles with wb_ready=1.
- An illegal head costs one cycle and produces no writeback.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Reset asserted mid-operation aborts immediately; outputs return to reset values asynchronously.

## Structure
- Shared package vsfx_pkg holds:
  - opcode constants (OP_VADDSWS, OP_VSUBUBM, OP_VAVGSH, OP_VCMPEQUH, OP_VSLB)
  - FSM state encoding (IDLE/EXEC/WB)
  - CR6 encodings (CR6_ALL=4'b1000, CR6_NONE=4'b0010)
- Sub-module vsfx_issue_fifo (DEPTH × 269 bits: ins+vra+vrb+tag) with full/empty flags and wrapping pointers.
- FSM, counter, SAT and CR6 logic live in the top.

## Test plan
- Single vaddsws, vra word0=0x7FFFFFFF, vrb word0=1, dp model saturates (dp_sat=1) → wb_valid at cycle 3, wb_tag echoed, sat_sticky=1 and stays 1 after the next non-saturating op.
- vcmpequh with equal operands → wb_cr6=4'b1000, wb_cr6_we=1. Fully unequal operands → 4'b0010. Mixed → 4'b0000.
- Fill with DEPTH+1 ops while wb_ready=0 → in_ready=0 after 4 queued + 1 in WB; release wb_ready → results in order, FIFO pointers wrap, all 5 tags correct.
- Opcode 0xFF between two vslb → one-cycle illegal pulse, exactly two writebacks, no dp_en for 0xFF.
- flush asserted during EXEC with 2 ops queued → no wb_valid, busy=0 next cycle. Subsequent op completes normally. sat_sticky unchanged.
- sat_clr asserted in the same cycle as a saturating capture → sat_sticky=1. rst_n pulsed low during WB → wb_valid=0 immediately.
